// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg: definitions shared by the frame-buffer scanout block.
//   scan_state_e : scan sequencer states (IDLE=0, RUN=1, DRAIN=2)
//   PIX_W        : RGB888 pixel width
//   ADDR_W       : frame-buffer word address width
//   FIFO_W       : skid FIFO entry width ({pixel, sof, eol})
package fb_scanout_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } scan_state_e;

    localparam int PIX_W  = 24;
    localparam int ADDR_W = 20;
    localparam int FIFO_W = PIX_W + 2;

endpackage

// File: rtl/fb_skid_fifo.sv
// fb_skid_fifo: 2-entry FIFO that buffers frame-buffer read data on its way
// to the pixel stream.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write an entry (ignored when full)
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry, meaningful while valid
//   valid      : FIFO non-empty
//   count      : current occupancy (0..2)
module fb_skid_fifo
    import fb_scanout_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [FIFO_W-1:0] din,
    input  logic              pop,
    output logic [FIFO_W-1:0] dout,
    output logic              valid,
    output logic [1:0]        count
);

    logic [FIFO_W-1:0] mem_q [2];
    logic [FIFO_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push && (cnt_q != 2'd2);
        do_pop   = pop && (cnt_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Push and pop in the same cycle leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: reads one WIDTH x HEIGHT frame from a synchronous frame-buffer
// RAM in raster order and streams it out as valid/ready RGB888 pixels.
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle request to scan a frame (ignored while busy)
//   dim         : halve pixel intensity (only with FB_SCANOUT_DIM_EN defined)
//   FB_A, FB_Q  : RAM read address / read data (data one cycle after address)
//   pix_data    : {R,G,B}; pix_valid / pix_ready handshake
//   pix_sof     : pixel (0,0);  pix_eol : last pixel of a line
//   busy        : scan in progress; frame_done : pulse on final transfer
// Optional feature macro: FB_SCANOUT_DIM_EN (enables the dim path).
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE = 20'h00000,
    parameter int                WIDTH   = 256,
    parameter int                HEIGHT  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dim,
    output logic [ADDR_W-1:0] FB_A,
    input  logic [PIX_W-1:0]  FB_Q,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    scan_state_e       state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fb_a_q, fb_a_d;
    logic              infl_q, infl_d;
    logic              tag_sof_q, tag_sof_d;
    logic              tag_eol_q, tag_eol_d;

    logic              issue;
    logic              pop;
    logic              done_c;
    logic [2:0]        occ_sum;
    logic [PIX_W-1:0]  push_px;
    logic [FIFO_W-1:0] head;
    logic              fifo_valid;
    logic [1:0]        fifo_cnt;

`ifdef FB_SCANOUT_DIM_EN
    function automatic logic [PIX_W-1:0] dim_px(input logic [PIX_W-1:0] p);
        return {1'b0, p[23:17], 1'b0, p[15:9], 1'b0, p[7:1]};
    endfunction

    assign push_px = dim ? dim_px(FB_Q) : FB_Q;
`else
    logic dim_unused;
    assign dim_unused = dim;
    assign push_px    = FB_Q;
`endif

    assign pop = fifo_valid & pix_ready;

    // Outstanding work after this cycle's pop: buffered entries plus the read
    // whose data arrives next edge. Counting the pop lets a new read issue
    // every cycle while the consumer keeps up.
    assign occ_sum = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, pop};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        fb_a_d  = fb_a_q;
        issue   = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = FB_BASE;
                end
            end
            S_RUN: begin
                if (occ_sum < 3'd2) begin
                    issue  = 1'b1;
                    fb_a_d = addr_q;
                    // Raster order makes the address a plain 20-bit counter.
                    addr_d = addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                        if (y_q == Y_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // All reads issued: the last pixel is the only one left.
                if (pop && (fifo_cnt == 2'd1) && !infl_q) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        infl_d    = issue;
        tag_sof_d = (x_q == '0) && (y_q == '0);
        tag_eol_d = (x_q == X_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= FB_BASE;
            fb_a_q  <= FB_BASE;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            fb_a_q  <= fb_a_d;
            infl_q  <= infl_d;
        end
    end

    // Tags only matter alongside infl_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_sof_q <= tag_sof_d;
        tag_eol_q <= tag_eol_d;
    end

    // The address goes straight to the RAM in the issue cycle so its data is
    // on FB_Q in time to be pushed at the following edge.
    assign FB_A = issue ? addr_q : fb_a_q;

    fb_skid_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (infl_q),
        .din   ({push_px, tag_sof_q, tag_eol_q}),
        .pop   (pop),
        .dout  (head),
        .valid (fifo_valid),
        .count (fifo_cnt)
    );

    // Outputs are gated so stale storage never shows while the FIFO is empty.
    assign pix_valid  = fifo_valid;
    assign pix_data   = fifo_valid ? head[FIFO_W-1:2] : '0;
    assign pix_sof    = fifo_valid & head[1];
    assign pix_eol    = fifo_valid & head[0];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_c;

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

    localparam logic [19:0] A_BASE = 20'h00100;
    localparam int          A_W    = 4;
    localparam int          A_N    = 8;
    localparam logic [19:0] B_BASE = 20'hFFFFE;
    localparam int          B_W    = 4;
    localparam int          B_N    = 4;
`ifdef FB_SCANOUT_DIM_EN
    localparam logic [23:0] OVR_EXP = 24'h7F4000;
`else
    localparam logic [23:0] OVR_EXP = 24'hFF8001;
`endif

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
        logic        eol;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, dim, pix_ready, ovr, sel;
    logic [19:0] fba_a, fba_b;
    logic [23:0] fbq_a, fbq_b, pd_a, pd_b;
    logic        pv_a, pv_b, sof_a, sof_b, eol_a, eol_b;
    logic        busy_a, busy_b, fd_a, fd_b;

    logic        obs_valid, obs_sof, obs_eol, obs_busy, obs_fd;
    logic [23:0] obs_data;
    logic [19:0] obs_fa, cur_base;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_cnt = 0;
    int          fd_cnt  = 0;
    logic        stall_prev = 1'b0;
    logic        fd_prev    = 1'b0;
    logic [23:0] stall_data;
    logic [19:0] diff;

    always #5 clk = ~clk;

    fb_scanout #(.FB_BASE(A_BASE), .WIDTH(4), .HEIGHT(2)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .dim(dim),
        .FB_A(fba_a), .FB_Q(fbq_a), .pix_data(pd_a), .pix_valid(pv_a),
        .pix_ready(pix_ready), .pix_sof(sof_a), .pix_eol(eol_a),
        .busy(busy_a), .frame_done(fd_a)
    );

    fb_scanout #(.FB_BASE(B_BASE), .WIDTH(4), .HEIGHT(1)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .dim(dim),
        .FB_A(fba_b), .FB_Q(fbq_b), .pix_data(pd_b), .pix_valid(pv_b),
        .pix_ready(pix_ready), .pix_sof(sof_b), .pix_eol(eol_b),
        .busy(busy_b), .frame_done(fd_b)
    );

    function automatic logic [23:0] pix_of(input logic [19:0] a);
        return {4'hA, a};
    endfunction

    // Synchronous RAM models: data for the address seen at an edge is on FB_Q
    // for the following cycle.
    always @(posedge clk) begin
        fbq_a <= ovr ? 24'hFF8001 : pix_of(fba_a);
        fbq_b <= pix_of(fba_b);
    end

    assign obs_valid = sel ? pv_b   : pv_a;
    assign obs_sof   = sel ? sof_b  : sof_a;
    assign obs_eol   = sel ? eol_b  : eol_a;
    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_fd    = sel ? fd_b   : fd_a;
    assign obs_data  = sel ? pd_b   : pd_a;
    assign obs_fa    = sel ? fba_b  : fba_a;
    assign cur_base  = sel ? B_BASE : A_BASE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability, read-ahead bound.
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev) chk("hold", 32'(obs_data), 32'(stall_data));
            if (fd_prev) chk("busy_drop", 32'(obs_busy), 32'd0);
            if (obs_busy) begin
                diff = obs_fa - cur_base - 20'(acc_cnt);
                chk("ahead", 32'(diff <= 20'd2), 32'd1);
            end
            if (obs_valid && pix_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_pix", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("data", 32'(obs_data), 32'(mon_e.d));
                    chk("sof", 32'(obs_sof), 32'(mon_e.sof));
                    chk("eol", 32'(obs_eol), 32'(mon_e.eol));
                    chk("frame_done", 32'(obs_fd), 32'(sb.size() == 0));
                end
                acc_cnt++;
            end else if (obs_fd) begin
                chk("fd_spur", 32'd1, 32'd0);
            end
            if (obs_fd) fd_cnt++;
            stall_prev = obs_valid && !pix_ready;
            stall_data = obs_data;
            fd_prev    = obs_fd;
        end else begin
            stall_prev = 1'b0;
            fd_prev    = 1'b0;
        end
    end

    task automatic push_frame(input bit use_b);
        logic [19:0] base;
        int          w, n;
        exp_t        e;
        base = use_b ? B_BASE : A_BASE;
        w    = use_b ? B_W : A_W;
        n    = use_b ? B_N : A_N;
        for (int i = 0; i < n; i++) begin
            e.d   = ovr ? OVR_EXP : pix_of(base + 20'(i));
            e.sof = (i == 0);
            e.eol = ((i % w) == (w - 1));
            sb.push_back(e);
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
    task automatic run_frame(input bit use_b, input int mode, input int restart_at);
        sel     = use_b;
        acc_cnt = 0;
        fd_cnt  = 0;
        push_frame(use_b);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int k = 1; k <= 300 && fd_cnt == 0; k++) begin
            if (k == restart_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            pix_ready = (mode == 0) ? 1'b1 : ((k % 4 == 1) || (k % 4 == 0));
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            if (mode == 0 && k == 1) chk("lat_early", 32'(obs_valid), 32'd0);
            if (mode == 0 && k == 2) chk("lat_first", 32'(obs_valid), 32'd1);
        end
        pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("fd_count", 32'(fd_cnt), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("idle_busy", 32'(obs_busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        dim       = 1'b0;
        pix_ready = 1'b1;
        ovr       = 1'b0;
        sel       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(pv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_fd", 32'(fd_a), 32'd0);
        chk("rst_data", 32'(pd_a), 32'd0);
        chk("rst_sof", 32'(sof_a), 32'd0);
        chk("rst_eol", 32'(eol_a), 32'd0);
        chk("rst_fba", 32'(fba_a), 32'(A_BASE));
        chk("rst_fbb", 32'(fba_b), 32'(B_BASE));

        // Back-to-back frame, then a stalled frame, then the wrapping frame
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 1, 0);
        run_frame(1'b1, 0, 0);

        // Reset after the third transfer, then a fresh frame from (0,0)
        sel       = 1'b0;
        acc_cnt   = 0;
        fd_cnt    = 0;
        pix_ready = 1'b1;
        push_frame(1'b0);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 0; k < 50 && acc_cnt < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_wait", 32'(acc_cnt), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        acc_cnt = 0;
        fd_cnt  = 0;
        chk("midrst_valid", 32'(pv_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_fba", 32'(fba_a), 32'(A_BASE));
        run_frame(1'b0, 0, 0);

        // start while busy is ignored
        run_frame(1'b0, 0, 3);
        run_frame(1'b0, 1, 6);

        // dim path
        ovr = 1'b1;
        dim = 1'b1;
        run_frame(1'b0, 0, 0);
        ovr = 1'b0;
        dim = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
